sanduba_cliente: RTL

Customer-side order sequencer for the sandwich vending machine: accepts one order (sandwich choice plus coin count) from an upstream controller, drives the machine's user inputs (`m100`, `dev`, `r_green`, `r_atum`, `r_bacon`) as single-cycle pulses paced by `busy`, and collects the machine's outputs (`green`, `atum`, `bacon`, `d100`) into a per-order response. It sits on the opposite side of the machine's user interface, acting as its initiator. It is also used as the stimulus driver in system-level benches.

---
 rtl/sanduba_cliente.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sanduba_cliente.sv
// sanduba_cliente: customer-side order sequencer for the sandwich vending machine.
// Takes one order from an upstream controller and replays it into the machine as
// paced single-cycle pulses. It also collects the machine's responses for that order.
// Optional feature: define SANDUBA_PRECHECK_EN to refuse underpaid sandwich orders
// locally, without touching the machine.
module sanduba_cliente #(
  parameter int unsigned GREEN_PRICE = 2,
  parameter int unsigned ATUM_PRICE  = 3,
  parameter int unsigned BACON_PRICE = 4,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ord_valid,
  output logic       ord_ready,
  input  logic [1:0] ord_item,
  input  logic [2:0] ord_coins,
  output logic       m100,
  output logic       dev,
  output logic       r_green,
  output logic       r_atum,
  output logic       r_bacon,
  input  logic       green,
  input  logic       atum,
  input  logic       bacon,
  input  logic       d100,
  input  logic       busy,
  output logic       done,
  output logic       rsp_item_ok,
  output logic       rsp_wrong,
  output logic [2:0] rsp_change,
  output logic       rsp_timeout,
  output logic       rsp_refused
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PULSE, S_GAP, S_DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_item;
  logic [2:0]      r_coins_left;
  logic            r_req_sent;
  logic            r_is_req;
  logic [TW-1:0]   r_tmo;

  logic [2:0]      w_sand;
  logic [2:0]      w_want;
  logic [31:0]     w_price;
  logic            w_short;

  // Sandwich outputs seen this cycle and the one the latched order asked for
  always_comb begin
    w_sand = {bacon, atum, green};
    w_want = 3'b000;
    case (r_item)
      2'd0:    w_want = 3'b001;
      2'd1:    w_want = 3'b010;
      2'd2:    w_want = 3'b100;
      default: w_want = 3'b000;
    endcase
  end

  // Price of the offered item and whether the offered coins fall short of it
  always_comb begin
    case (ord_item)
      2'd1:    w_price = 32'(ATUM_PRICE);
      2'd2:    w_price = 32'(BACON_PRICE);
      default: w_price = 32'(GREEN_PRICE);
    endcase
    w_short = (ord_item != 2'd3) && (32'(ord_coins) < w_price);
  end

`ifndef SANDUBA_PRECHECK_EN
  logic w_unused_short;
  assign w_unused_short = w_short;
  assign rsp_refused    = 1'b0;
`endif

  // Order sequencer with registered machine inputs and response monitor
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_item       <= 2'd0;
      r_coins_left <= 3'd0;
      r_req_sent   <= 1'b0;
      r_is_req     <= 1'b0;
      r_tmo        <= '0;
      ord_ready    <= 1'b0;
      m100         <= 1'b0;
      dev          <= 1'b0;
      r_green      <= 1'b0;
      r_atum       <= 1'b0;
      r_bacon      <= 1'b0;
      done         <= 1'b0;
      rsp_item_ok  <= 1'b0;
      rsp_wrong    <= 1'b0;
      rsp_change   <= 3'd0;
      rsp_timeout  <= 1'b0;
`ifdef SANDUBA_PRECHECK_EN
      rsp_refused  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          ord_ready <= 1'b1;
          if (ord_ready && ord_valid) begin
            ord_ready    <= 1'b0;
            r_item       <= ord_item;
            r_coins_left <= ord_coins;
            r_req_sent   <= 1'b0;
            r_tmo        <= '0;
            rsp_item_ok  <= 1'b0;
            rsp_wrong    <= 1'b0;
            rsp_change   <= 3'd0;
            rsp_timeout  <= 1'b0;
`ifdef SANDUBA_PRECHECK_EN
            rsp_refused  <= 1'b0;
            if (w_short) begin
              rsp_refused <= 1'b1;
              done        <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_WAIT;
            end
`else
            r_state      <= S_WAIT;
`endif
          end
        end
        S_WAIT: begin
          if (!busy) begin
            if (r_coins_left != 3'd0) begin
              m100     <= 1'b1;
              r_is_req <= 1'b0;
              r_state  <= S_PULSE;
            end else if (!r_req_sent) begin
              case (r_item)
                2'd0:    r_green <= 1'b1;
                2'd1:    r_atum  <= 1'b1;
                2'd2:    r_bacon <= 1'b1;
                default: dev     <= 1'b1;
              endcase
              r_is_req <= 1'b1;
              r_state  <= S_PULSE;
            end else begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (r_tmo == TW'(TIMEOUT - 1)) begin
            rsp_timeout <= 1'b1;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_PULSE: begin
          m100    <= 1'b0;
          dev     <= 1'b0;
          r_green <= 1'b0;
          r_atum  <= 1'b0;
          r_bacon <= 1'b0;
          if (r_is_req) r_req_sent <= 1'b1;
          else          r_coins_left <= r_coins_left - 3'd1;
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_DONE: begin
          done      <= 1'b0;
          ord_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if ((r_state == S_WAIT) || (r_state == S_PULSE) || (r_state == S_GAP)) begin
        if (d100 && (rsp_change != 3'd7)) rsp_change <= rsp_change + 3'd1;
        if (|(w_sand & w_want))  rsp_item_ok <= 1'b1;
        if (|(w_sand & ~w_want)) rsp_wrong   <= 1'b1;
      end
    end
  end

endmodule
